// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader for the instruction memory write port.
// Receives a byte stream over a valid/ready handshake:
//   count hi, count lo, N x (word hi, word lo), checksum (XOR of data bytes).
// Each assembled big-endian word is written to consecutive word addresses
// starting at 0. The core is held in reset until a load completes with a
// matching checksum.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, begins a load when not busy
//   in_valid   host byte valid
//   in_data    host byte
//   in_ready   loader can accept a byte this cycle
//   we         instruction memory write enable (one pulse per word)
//   waddr      word address of the current write
//   wdata      instruction word of the current write
//   busy       load in progress
//   done       last load succeeded (held until next start or reset)
//   err        last load failed (held until next start or reset)
//   cpu_rst_n  active-low core reset, released only after a good load
module imem_loader #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DAT_HI,
    DAT_LO,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  // One bit wider than the address so a full-depth load does not wrap.
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        csum_q, csum_d;

  logic              xfer;
  logic [16:0]       n_words;
  logic [16:0]       idx_next;

  // Outputs are pure decodes of registered state, so nothing on the host
  // side can reach an output combinationally.
  assign in_ready  = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                     (state_q == DAT_HI) || (state_q == DAT_LO) ||
                     (state_q == CSUM);
  assign we        = (state_q == WRITE);
  assign waddr     = idx_q[ADDR_W-1:0];
  assign wdata     = {hi_q, lo_q};
  assign busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign cpu_rst_n = (state_q == DONE);

  assign xfer     = in_valid && in_ready;
  // Full count as it will be once the low byte lands, widened so the
  // comparison against DEPTH cannot overflow.
  assign n_words  = {1'b0, cnt_q[15:8], in_data};
  assign idx_next = 17'(idx_q) + 17'd1;

  // State and datapath registers; reset returns to IDLE with all outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
    end
  end

  // Next-state logic: each receive state waits for a transfer; WRITE is a
  // single stall cycle that issues the memory write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    csum_d  = csum_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = CNT_HI;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          cnt_d[15:8] = in_data;
          state_d     = CNT_LO;
        end
      end
      CNT_LO: begin
        if (xfer) begin
          cnt_d[7:0] = in_data;
          if (n_words > DEPTH_W) begin
            state_d = ERR;
          end else if (n_words == 17'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DAT_HI;
          end
        end
      end
      DAT_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = DAT_LO;
        end
      end
      DAT_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + 1'b1;
        if (idx_next < {1'b0, cnt_q}) begin
          state_d = DAT_HI;
        end else begin
          state_d = CSUM;
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. A host driver pushes the expected
// {waddr, wdata} of every word onto a scoreboard queue as it sends the word;
// a negedge monitor pops and compares on every write pulse and also checks
// that the handshake and status outputs stay mutually consistent.
module tb_imem_loader;

  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_rst_n;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int writes_seen = 0;
  logic [ADDR_W-1:0] last_waddr;

  logic [ADDR_W+15:0] exp_q[$];
  logic [15:0]        words_q[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_rst_n (cpu_rst_n)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop on each write plus decode consistency checks.
  always @(negedge clk) begin
    logic [ADDR_W+15:0] exp_w;
    if (rst_n) begin
      checks++;
      if (in_ready !== (busy && !we)) begin
        failures++;
        $display("[TB] FAIL ready_decode in_ready=%b busy=%b we=%b at cyc %0d", in_ready, busy, we, cyc);
      end
      checks++;
      if ((cpu_rst_n !== done) || (done && err)) begin
        failures++;
        $display("[TB] FAIL status_decode cpu_rst_n=%b done=%b err=%b at cyc %0d", cpu_rst_n, done, err, cyc);
      end
      if (we) begin
        checks++;
        writes_seen++;
        last_waddr = waddr;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_we got waddr=%h wdata=%h, none expected", waddr, wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({waddr, wdata} !== exp_w) begin
            failures++;
            $display("[TB] FAIL write got waddr=%h wdata=%h exp waddr=%h wdata=%h",
                     waddr, wdata, exp_w[ADDR_W+15:16], exp_w[15:0]);
          end
        end
      end
    end
  end

  // Offer one byte after an optional random gap and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int tmo;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    tmo = 0;
    while (!in_ready && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL handshake_timeout byte=%h in_ready=%b exp 1", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Full stream from words_q: start, count, words, checksum^flip.
  // Returns the number of edges from the start edge to the final edge.
  task automatic run_stream(input int max_gap, input logic [7:0] flip,
                            input int start_after_word, output int edges);
    logic [7:0]  cs;
    logic [15:0] n;
    int c0;
    cs = 8'h00;
    n  = 16'(words_q.size());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    send_byte(n[15:8], max_gap);
    send_byte(n[7:0], max_gap);
    for (int i = 0; i < words_q.size(); i++) begin
      exp_q.push_back({ADDR_W'(i), words_q[i]});
      cs = cs ^ words_q[i][15:8] ^ words_q[i][7:0];
      send_byte(words_q[i][15:8], max_gap);
      send_byte(words_q[i][7:0], max_gap);
      if (i == start_after_word) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    send_byte(cs ^ flip, max_gap);
    edges = cyc - c0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #1;
    checks++;
    if ({in_ready, we, waddr, wdata, busy, done, err, cpu_rst_n} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got %h exp 0",
               {in_ready, we, waddr, wdata, busy, done, err, cpu_rst_n});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int edges;
    int w0;
    w0 = writes_seen;
    words_q = '{16'h1234, 16'hABCD, 16'h0F0F};
    run_stream(0, 8'h00, -1, edges);
    checks++;
    if (edges !== 12) begin
      failures++;
      $display("[TB] FAIL basic_latency got %0d exp 12", edges);
    end
    checks++;
    if ({done, err, cpu_rst_n, busy} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL basic_status got done/err/cpu/busy=%b exp 1010", {done, err, cpu_rst_n, busy});
    end
    checks++;
    if ((writes_seen - w0) !== 3 || exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL basic_writes got %0d pending %0d exp 3 pending 0", writes_seen - w0, exp_q.size());
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL done_hold got %b exp 1", done);
    end
  endtask

  task automatic test_gaps();
    int edges;
    int w0;
    w0 = writes_seen;
    words_q = '{16'h1234, 16'hABCD, 16'h0F0F};
    run_stream(5, 8'h00, -1, edges);
    checks++;
    if ({done, err, cpu_rst_n} !== 3'b101 || (writes_seen - w0) !== 3 || exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL gaps_result got done/err/cpu=%b writes=%0d exp 101 writes=3",
               {done, err, cpu_rst_n}, writes_seen - w0);
    end
  endtask

  task automatic test_zero_count();
    int edges;
    int w0;
    w0 = writes_seen;
    words_q = {};
    run_stream(0, 8'h00, -1, edges);
    checks++;
    if ({done, err, cpu_rst_n} !== 3'b101 || writes_seen !== w0) begin
      failures++;
      $display("[TB] FAIL zero_good got done/err/cpu=%b writes=%0d exp 101 writes=0",
               {done, err, cpu_rst_n}, writes_seen - w0);
    end
    run_stream(0, 8'h01, -1, edges);
    checks++;
    if ({done, err, cpu_rst_n} !== 3'b010 || writes_seen !== w0) begin
      failures++;
      $display("[TB] FAIL zero_bad got done/err/cpu=%b writes=%0d exp 010 writes=0",
               {done, err, cpu_rst_n}, writes_seen - w0);
    end
  endtask

  task automatic test_overflow();
    int w0;
    w0 = writes_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    checks++;
    if ({err, done, busy, in_ready} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL overflow_err got err/done/busy/rdy=%b exp 1000", {err, done, busy, in_ready});
    end
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || err !== 1'b1 || writes_seen !== w0) begin
      failures++;
      $display("[TB] FAIL overflow_idle got rdy=%b err=%b writes=%0d exp 0 1 0", in_ready, err, writes_seen - w0);
    end
  endtask

  task automatic test_full_depth();
    int edges;
    int w0;
    w0 = writes_seen;
    words_q = {};
    for (int i = 0; i < DEPTH; i++) words_q.push_back(16'($urandom));
    run_stream(0, 8'h00, -1, edges);
    checks++;
    if ({done, err} !== 2'b10 || (writes_seen - w0) !== DEPTH || last_waddr !== 12'hFFF) begin
      failures++;
      $display("[TB] FAIL full_depth got done/err=%b writes=%0d last=%h exp 10 4096 fff",
               {done, err}, writes_seen - w0, last_waddr);
    end
    checks++;
    if (edges !== 2 + 3 * DEPTH + 1) begin
      failures++;
      $display("[TB] FAIL full_latency got %0d exp %0d", edges, 2 + 3 * DEPTH + 1);
    end
  endtask

  task automatic test_bad_then_good();
    int edges;
    int w0;
    w0 = writes_seen;
    words_q = '{16'hCAFE, 16'h0001};
    run_stream(2, 8'h80, -1, edges);
    checks++;
    if ({done, err, cpu_rst_n} !== 3'b010 || (writes_seen - w0) !== 2) begin
      failures++;
      $display("[TB] FAIL bad_csum got done/err/cpu=%b writes=%0d exp 010 writes=2",
               {done, err, cpu_rst_n}, writes_seen - w0);
    end
    words_q = '{16'h5A5A, 16'h8001};
    run_stream(0, 8'h00, -1, edges);
    checks++;
    if ({done, err, cpu_rst_n} !== 3'b101 || exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL reload got done/err/cpu=%b pending=%0d exp 101 pending 0",
               {done, err, cpu_rst_n}, exp_q.size());
    end
  endtask

  task automatic test_reset_midload();
    int w0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    exp_q.push_back({12'h000, 16'h7E81});
    send_byte(8'h7E, 0);
    send_byte(8'h81, 0);
    send_byte(8'h99, 0);
    w0 = writes_seen;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, we, waddr, wdata, busy, done, err, cpu_rst_n} !== '0) begin
      failures++;
      $display("[TB] FAIL midload_reset got %h exp 0",
               {in_ready, we, waddr, wdata, busy, done, err, cpu_rst_n});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h42;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (writes_seen !== w0 || busy !== 1'b0 || exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL midload_after got writes=%0d busy=%b pending=%0d exp 0 0 0",
               writes_seen - w0, busy, exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    int edges;
    int w0;
    w0 = writes_seen;
    words_q = '{16'h1111, 16'h2222, 16'h3333};
    run_stream(0, 8'h00, 0, edges);
    checks++;
    if ({done, err} !== 2'b10 || (writes_seen - w0) !== 3 || exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL start_ignored got done/err=%b writes=%0d exp 10 writes=3",
               {done, err}, writes_seen - w0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_count();
    test_overflow();
    test_bad_then_good();
    test_reset_midload();
    test_start_ignored();
    test_full_depth();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the instruction memory's write port. It consumes a byte stream from a host link (UART receiver or test harness) over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes each word to consecutive word addresses starting at 0, checks an XOR checksum, and holds the processor core in reset until a load completes cleanly.

## Interface

Parameters:
- DEPTH, 4096, instruction memory depth in 16-bit words.
- ADDR_W, $clog2(DEPTH), word-address width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts a byte; a transfer occurs on a cycle with in_valid && in_ready.
- we  out  1  instruction memory write enable; one-cycle pulse per word.
- waddr  out  ADDR_W  word address of the current write.
- wdata  out  16  instruction word to write.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded; held until the next start or reset.
- err  out  1  last load failed; held until the next start or reset.
- cpu_rst_n  out  1  active-low core reset; low except in DONE.

## Operation

- Stream format, in order:
  - count high byte, then count low byte: N is the number of words, 16-bit.
  - N words, each as high byte then low byte.
  - One checksum byte, equal to the XOR of all 2N data bytes. The count bytes are excluded.
- FSM states: IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start → CNT_HI. This clears done, err, the word index and the checksum accumulator, and drives cpu_rst_n low.
- CNT_HI: on transfer, latch N[15:8] → CNT_LO.
- CNT_LO: on transfer, latch N[7:0], then branch:
  - N > DEPTH → ERR.
  - N == 0 → CSUM.
  - otherwise → DAT_HI.
- DAT_HI: on transfer, latch the high byte and fold it into the checksum → DAT_LO.
- DAT_LO: on transfer, latch the low byte and fold it into the checksum → WRITE.
- WRITE, one cycle:
  - we=1, waddr=index, wdata={hi,lo}.
  - index increments.
  - → DAT_HI if index+1 < N, else → CSUM.
- CSUM: on transfer, if the byte equals the accumulator → DONE, else → ERR.
- in_ready = 1 exactly in CNT_HI, CNT_LO, DAT_HI, DAT_LO, CSUM. It is 0 in IDLE, WRITE, DONE, ERR.
- busy = 1 in every state except IDLE, DONE, ERR.
- done = 1 only in DONE; err = 1 only in ERR.
- cpu_rst_n = 1 only in DONE. A failed load leaves the core in reset.
- start in any busy state is ignored.
- Bytes offered while in_ready=0 are not consumed; the host must hold them.
- Index is ADDR_W+1 bits wide, so N == DEPTH completes without wrap. The last write goes to waddr = DEPTH-1.
- Unwritten memory locations beyond N-1 are not touched.

## Timing

- Reset (rst_n low, asynchronous):
  - State IDLE.
  - in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_rst_n=0.
- Reset mid-load aborts immediately; no further writes occur and the loader returns to IDLE.
- All outputs are registered or decoded from registered state; there is no combinational path from in_valid or in_data to any output.
- start accepted at edge t → CNT_HI, with in_ready=1 from cycle t+1.
- Low-byte transfer at edge t → we=1 during cycle t+1. in_ready=0 during that cycle, so there is exactly one stall cycle per word.
- Minimum load time with no host gaps: 2 + 3N + 1 cycles from the first in_ready to the DONE entry edge.
- Checksum transfer at edge t → done or err valid and cpu_rst_n updated in cycle t+1.
- Host gaps (in_valid=0) of any length stall the FSM in its current state with no side effects.

## Test plan

- Load N=3: words 0x1234, 0xABCD, 0x0F0F, checksum 0x12^0x34^0xAB^0xCD^0x0F^0x0F = 0x40, no gaps → three we pulses at waddr 0,1,2 with matching wdata; done=1, cpu_rst_n=1, err=0; total 2+9+1 accepted-byte/write cycles.
- Same stream with random in_valid gaps of 0–5 cycles → identical writes and result; in_ready low only in WRITE cycles and outside busy.
- N=0 followed by checksum 0x00 → no we pulses, done=1. Repeat with checksum 0x01 → err=1, cpu_rst_n stays 0.
- Count 0x1001 (4097 > DEPTH) → ERR right after the count low byte, no writes, in_ready=0 afterwards. Count 0x1000 with a valid stream → last write at waddr 0xFFF, done=1.
- Corrupted checksum on an N=2 load → both words still written, err=1, done=0, cpu_rst_n=0. A new start then performs a good load → done=1, err cleared.
- rst_n pulsed low after the 2nd word's high byte → all outputs return to reset values immediately, no further we. start pulsed during busy → ignored, and the stream continues correctly.
